// File: rtl/snake_pkg.sv
// Shared direction encodings, PS2 set-2 scan codes and parser states for the snake direction path.
// Directions are one-hot so the movement logic can consume them without decoding.
package snake_pkg;

    localparam logic [3:0] DIR_IDLE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} parseState_t;

    function automatic logic [3:0] oppositeDir(input logic [3:0] dir);
        case (dir)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return DIR_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// Pending-turn queue: DEPTH entries of 4-bit direction, head/tail visible combinationally, level updates next edge.
// No internal guarding: the owner must not push when full without a pop, nor pop when empty.
module snake_dir_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [3:0]       pushDir,
    output logic [3:0]       head,
    output logic [3:0]       tail,
    output logic [LVL_W-1:0] level,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]       mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] lastPtr;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign lastPtr = (wrPtr == '0) ? PTR_W'(DEPTH - 1) : wrPtr - 1'b1;
    assign head    = mem[rdPtr];
    assign tail    = mem[lastPtr];
    assign full    = (level == LVL_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= pushDir;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            level <= '0;
        end else if (clear) begin
            rdPtr <= '0;
            wrPtr <= '0;
            level <= '0;
        end else begin
            if (push) wrPtr <= nextPtr(wrPtr);
            if (pop)  rdPtr <= nextPtr(rdPtr);
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Decodes PS2 arrow/WASD make codes into validated turns, queues them, and applies one per game tick.
// Key to queue_level: 1 cycle; tick to direction: 1 cycle; turns arriving at a full queue are dropped and flagged.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int LVL_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       scan_byte,
    input  logic             scan_valid,
    input  logic             tick,
    input  logic             game_rst,
    output logic [3:0]       direction,
    output logic             dir_change,
    output logic [LVL_W-1:0] queue_level,
    output logic             overflow
);

    parseState_t      state;
    logic             keyVld;
    logic [3:0]       keyDir;
    logic [3:0]       refDir;
    logic             accept;
    logic             doPush;
    logic             doPop;
    logic [3:0]       qHead;
    logic [3:0]       qTail;
    logic [LVL_W-1:0] qLevel;
    logic             qFull;

    always_comb begin
        keyVld = 1'b0;
        keyDir = DIR_IDLE;
        if (scan_valid) begin
            case (state)
                IDLE: case (scan_byte)
                    SC_W:    begin keyVld = 1'b1; keyDir = DIR_UP;    end
                    SC_A:    begin keyVld = 1'b1; keyDir = DIR_LEFT;  end
                    SC_S:    begin keyVld = 1'b1; keyDir = DIR_DOWN;  end
                    SC_D:    begin keyVld = 1'b1; keyDir = DIR_RIGHT; end
                    default: ;
                endcase
                EXT: case (scan_byte)
                    SC_UP:    begin keyVld = 1'b1; keyDir = DIR_UP;    end
                    SC_LEFT:  begin keyVld = 1'b1; keyDir = DIR_LEFT;  end
                    SC_DOWN:  begin keyVld = 1'b1; keyDir = DIR_DOWN;  end
                    SC_RIGHT: begin keyVld = 1'b1; keyDir = DIR_RIGHT; end
                    default:  ;
                endcase
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (game_rst) begin
            state <= IDLE;
        end else if (scan_valid) begin
            case (state)
                IDLE:    state <= (scan_byte == SC_EXT) ? EXT :
                                  (scan_byte == SC_BRK) ? BRK : IDLE;
                EXT:     state <= (scan_byte == SC_BRK) ? EXT_BRK : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Validate against the newest queued turn so a burst of taps chains correctly.
    assign refDir = (qLevel != '0) ? qTail : direction;
    assign accept = keyVld && ((refDir == DIR_IDLE) ||
                               (keyDir != refDir && keyDir != oppositeDir(refDir)));
    assign doPop  = tick && (qLevel != '0) && !game_rst;
    assign doPush = accept && (!qFull || doPop) && !game_rst;

    snake_dir_fifo #(
        .DEPTH (QDEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (game_rst),
        .push    (doPush),
        .pop     (doPop),
        .pushDir (keyDir),
        .head    (qHead),
        .tail    (qTail),
        .level   (qLevel),
        .full    (qFull)
    );

    assign queue_level = qLevel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            direction  <= DIR_IDLE;
            dir_change <= 1'b0;
            overflow   <= 1'b0;
        end else if (game_rst) begin
            direction  <= DIR_IDLE;
            dir_change <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            dir_change <= doPop;
            if (doPop) direction <= qHead;
            if (accept && qFull && !doPop && !game_rst) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed plus random stimulus for snake_dir_ctrl against a queue-based reference model.
module tb_snake_dir_ctrl;

    localparam int QDEPTH = 2;
    localparam int LVL_W  = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       scan_byte;
    logic             scan_valid;
    logic             tick;
    logic             game_rst;
    logic [3:0]       direction;
    logic             dir_change;
    logic [LVL_W-1:0] queue_level;
    logic             overflow;

    always #5 clk = ~clk;

    snake_dir_ctrl #(.QDEPTH(QDEPTH), .LVL_W(LVL_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_byte   (scan_byte),
        .scan_valid  (scan_valid),
        .tick        (tick),
        .game_rst    (game_rst),
        .direction   (direction),
        .dir_change  (dir_change),
        .queue_level (queue_level),
        .overflow    (overflow)
    );

    int nChecks = 0;
    int nPass   = 0;
    int nFail   = 0;
    string curStep = "init";

    // Reference model: direction index 0=up 1=left 2=down 3=right, -1 = idle.
    int         mDir;
    int         mQ[$];
    bit         mOvf;
    bit         mChg;
    logic [7:0] mPre[$];
    logic [7:0] wasdCodes[4]  = '{8'h1D, 8'h1C, 8'h1B, 8'h23};
    logic [7:0] arrowCodes[4] = '{8'h75, 8'h6B, 8'h72, 8'h74};
    logic [7:0] pool[10] = '{8'hE0, 8'hF0, 8'h75, 8'h6B, 8'h72, 8'h74,
                             8'h1D, 8'h1C, 8'h1B, 8'h23};

    function automatic logic [3:0] onehot(input int d);
        return (d < 0) ? 4'b0000 : 4'(1 << d);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("FAIL %s.%s: observed %0h expected %0h", curStep, tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        mDir = -1;
        mQ.delete();
        mOvf = 1'b0;
        mChg = 1'b0;
        mPre.delete();
    endtask

    // Collect prefix bytes until a sequence completes; only E0-or-empty prefixes yield keys.
    task automatic modelByte(input logic [7:0] b, output int cand);
        cand = -1;
        if (mPre.size() == 0 && (b == 8'hE0 || b == 8'hF0)) begin
            mPre.push_back(b);
        end else if (mPre.size() == 1 && mPre[0] == 8'hE0 && b == 8'hF0) begin
            mPre.push_back(b);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (mPre.size() == 0 && b == wasdCodes[i]) cand = i;
                if (mPre.size() == 1 && mPre[0] == 8'hE0 && b == arrowCodes[i]) cand = i;
            end
            mPre.delete();
        end
    endtask

    task automatic checkAll();
        chk("direction", 8'(direction), 8'(onehot(mDir)));
        chk("dir_change", 8'(dir_change), 8'(mChg));
        chk("queue_level", 8'(queue_level), 8'(mQ.size()));
        chk("overflow", 8'(overflow), 8'(mOvf));
    endtask

    task automatic cycle(input logic [7:0] b, input logic v, input logic t, input logic g);
        int cand;
        int refd;
        bit acc;
        scan_byte  = b;
        scan_valid = v;
        tick       = t;
        game_rst   = g;
        if (g) begin
            modelClear();
        end else begin
            cand = -1;
            if (v) modelByte(b, cand);
            refd = (mQ.size() > 0) ? mQ[$] : mDir;
            acc  = (cand >= 0) && (refd < 0 || (cand != refd && cand != (refd + 2) % 4));
            mChg = 1'b0;
            if (t && mQ.size() > 0) begin
                mDir = mQ.pop_front();
                mChg = 1'b1;
            end
            if (acc) begin
                if (mQ.size() < QDEPTH) mQ.push_back(cand);
                else mOvf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        checkAll();
        scan_valid = 1'b0;
        tick       = 1'b0;
        game_rst   = 1'b0;
    endtask

    task automatic key(input logic [7:0] b);
        cycle(b, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic doTick();
        cycle(8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic pulseRst();
        rst_n = 1'b0;
        #2;
        chk("arst.direction", 8'(direction), 8'h00);
        chk("arst.dir_change", 8'(dir_change), 8'h00);
        chk("arst.queue_level", 8'(queue_level), 8'h00);
        chk("arst.overflow", 8'(overflow), 8'h00);
        modelClear();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; scan_byte = 8'h00; scan_valid = 1'b0; tick = 1'b0; game_rst = 1'b0;
        modelClear();
        repeat (2) @(posedge clk);
        #1;
        curStep = "reset";
        chk("direction", 8'(direction), 8'h00);
        chk("dir_change", 8'(dir_change), 8'h00);
        chk("queue_level", 8'(queue_level), 8'h00);
        chk("overflow", 8'(overflow), 8'h00);
        rst_n = 1'b1;

        curStep = "ext_up";
        key(8'hE0);
        key(8'h75);
        chk("level_after_push", 8'(queue_level), 8'd1);
        doTick();
        chk("dir_up", 8'(direction), 8'h01);
        chk("pulse", 8'(dir_change), 8'h01);
        chk("level_after_pop", 8'(queue_level), 8'd0);
        cycle(8'h00, 1'b0, 1'b0, 1'b0);
        chk("pulse_one_cycle", 8'(dir_change), 8'h00);

        curStep = "reverse";
        key(8'h1B);
        chk("level_rejected", 8'(queue_level), 8'd0);
        doTick();
        chk("dir_held", 8'(direction), 8'h01);
        chk("no_pulse", 8'(dir_change), 8'h00);

        curStep = "double_tap";
        key(8'h23);
        doTick();
        chk("dir_right", 8'(direction), 8'h08);
        key(8'h1D);
        key(8'h1C);
        chk("level_two", 8'(queue_level), 8'd2);
        doTick();
        chk("first_up", 8'(direction), 8'h01);
        doTick();
        chk("then_left", 8'(direction), 8'h02);

        curStep = "full";
        key(8'h1D);
        key(8'h1C);
        key(8'hE0);
        key(8'h72);
        chk("overflow_set", 8'(overflow), 8'h01);
        chk("level_full", 8'(queue_level), 8'd2);
        key(8'hE0);
        cycle(8'h72, 1'b1, 1'b1, 1'b0);
        chk("level_push_pop", 8'(queue_level), 8'd2);
        chk("dir_popped_up", 8'(direction), 8'h01);
        doTick();
        doTick();

        curStep = "breaks";
        key(8'hF0); key(8'h1D);
        key(8'hE0); key(8'hF0); key(8'h74);
        chk("no_push", 8'(queue_level), 8'd0);
        key(8'h23);
        chk("right_pushed", 8'(queue_level), 8'd1);
        doTick();
        chk("dir_right", 8'(direction), 8'h08);

        curStep = "game_rst";
        key(8'h1D); doTick();
        key(8'h1C); doTick();
        key(8'h1D); key(8'h23);
        key(8'h1B);
        chk("pre_dir_left", 8'(direction), 8'h02);
        cycle(8'h1B, 1'b1, 1'b1, 1'b1);
        chk("direction", 8'(direction), 8'h00);
        chk("queue_level", 8'(queue_level), 8'd0);
        chk("overflow", 8'(overflow), 8'h00);
        chk("dir_change", 8'(dir_change), 8'h00);

        curStep = "async_rst";
        key(8'h1C); doTick();
        key(8'h1D); key(8'h23); key(8'h1B);
        key(8'hE0);
        pulseRst();
        key(8'h75);
        chk("dangling_ext_cleared", 8'(queue_level), 8'd0);

        curStep = "random";
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] b;
            int sel;
            sel = $urandom_range(0, 10);
            if (sel == 10) b = 8'($urandom);
            else b = pool[sel];
            if ($urandom_range(0, 199) == 0) pulseRst();
            cycle(b, ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 99) == 0));
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Upstream stage of the snake game top level; sits between the PS2 receiver byte output and the game's movement logic.
- Parses PS2 set-2 scan bytes (arrow keys and WASD), discards break sequences, and rejects 180-degree reversals and repeats.
- Buffers accepted turns in a small queue and releases exactly one turn per game update tick, so quick double-taps between ticks are not lost.
- Drives the one-hot 4-bit direction the movement logic consumes.

Parameters:
- QDEPTH, 2, number of pending turns buffered (1..4).
- LVL_W, 3, width of queue_level; must hold 0..QDEPTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- scan_byte  in  8  scan code byte from the PS2 receiver.
- scan_valid  in  1  one-cycle strobe; scan_byte is valid in that cycle.
- tick  in  1  one-cycle game update strobe, synchronous to clk.
- game_rst  in  1  synchronous game restart; active high.
- direction  out  4  one-hot direction: 0001 up, 0010 left, 0100 down, 1000 right, 0000 idle.
- dir_change  out  1  one-cycle pulse in the cycle direction takes a new value.
- queue_level  out  LVL_W  number of pending entries.
- overflow  out  1  sticky flag; set when an accepted key is dropped because the queue is full.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - direction=0000, dir_change=0, queue_level=0, overflow=0.
  - Parser returns to IDLE; queue is emptied.
- game_rst=1 (synchronous): same clear as rst_n in the next cycle. It overrides scan_valid and tick in that cycle, and both inputs are ignored while it is high.
- Parser FSM, states IDLE, EXT, BRK, EXT_BRK; transitions happen only on cycles with scan_valid=1:
  - IDLE: E0 -> EXT; F0 -> BRK; 1D/1C/1B/23 -> key up/left/down/right, stay IDLE; any other byte -> IDLE.
  - EXT: F0 -> EXT_BRK; 75/6B/72/74 -> key up/left/down/right, then IDLE; any other byte -> IDLE.
  - BRK and EXT_BRK: any byte is consumed with no key, then IDLE.
  - A decoded key is a candidate in the same cycle as its scan_valid.
- Candidate validation, against a reference direction:
  - Reference = newest queue entry if the queue is non-empty at the start of the cycle; otherwise the current direction.
  - Reject if the candidate equals the reference.
  - Reject if the candidate is the opposite of the reference (up/down, left/right).
  - If the reference is 0000, any key is accepted.
- Push: an accepted candidate is written at the queue tail and becomes visible in queue_level in the next cycle.
- Full queue:
  - Without a pop in the same cycle: the candidate is dropped and overflow is set. overflow clears only on rst_n or game_rst.
  - With a simultaneous pop: push and pop both occur and queue_level is unchanged.
- Pop: on tick=1 with a non-empty queue, the head moves into direction on the next edge and dir_change=1 for that one cycle.
- tick with an empty queue: direction holds and dir_change stays 0.
- Latency: scan_valid of the final byte in cycle n means the earliest usable tick is in cycle n+1. A tick in cycle m updates direction at m+1.
- Simultaneous push and pop, one entry queued: validation uses the entry being popped, which becomes direction, so ordering stays consistent.
- No timeouts; a dangling E0 or F0 waits indefinitely for the next byte.

Decomposition:
- Shared package snake_pkg holds:
  - Direction encodings DIR_IDLE/UP/LEFT/DOWN/RIGHT.
  - Scan code constants: SC_EXT=E0, SC_BRK=F0, the arrow codes and the WASD codes.
  - A function returning the opposite of a direction.
- Sub-module snake_dir_fifo: synchronous FIFO, 4-bit wide, QDEPTH deep, with push, pop, head, tail, level and full, plus a synchronous clear. The parser FSM and validation stay in snake_dir_ctrl.

Test Plan:
- Reset, then bytes E0,75 and one tick -> direction=0001 with a one-cycle dir_change; queue_level goes 1 then 0.
- direction=0001; bytes 1B (S, down) then tick -> rejected, queue_level stays 0, direction stays 0001, no dir_change.
- direction=1000; bytes 1D then 1C before any tick (up then left) -> queue_level=2; tick gives 0001, next tick gives 0010.
- QDEPTH=2 holding two entries (up, then left); key E0,72 (down) without a tick -> dropped, overflow=1; same key in the same cycle as a tick -> accepted, queue_level stays 2.
- Bytes F0,1D then E0,F0,74 -> no pushes; parser back in IDLE; the next byte 23 pushes right.
- Mid-operation (two queued entries, direction=0010), assert game_rst for one cycle together with tick -> direction=0000, queue_level=0, overflow=0, no dir_change. Repeat with rst_n pulsed low between clock edges -> same state immediately.
